i2c_slave: RTL and testbench

- I2C target (responder) for the on-chip I2C bus; the counterpart to the team's I2C master.
- Detects START, repeated START and STOP. Matches a 7-bit address and ACKs it.
- Write transfers: delivers received bytes on a one-cycle-pulse byte interface.
- Read transfers: shifts out bytes supplied by the user.
- Fully synchronous to clk: SCL and SDA are oversampled. No clock stretching.

---
 rtl/i2c_slave.sv | 181 ++++++++++++++++++
 tb/tb_i2c_slave.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave.sv
// I2C target: oversampled SCL/SDA, 7-bit address match, byte-pulse write
// interface and user-fed read data. Open-drain SDA, no clock stretching.
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h42
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  inout  wire        sda,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_first,
  input  logic [7:0] tx_data,
  output logic       tx_load,
  output logic       mst_nack,
  output logic       busy,
  output logic       start_det,
  output logic       stop_det
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_WRITE, S_WR_ACK, S_READ, S_RD_ACK, S_IGNORE
  } state_t;

  state_t      state_q;
  logic        scl_s1_q, scl_s2_q, scl_prev_q;
  logic        sda_s1_q, sda_s2_q, sda_prev_q;
  logic [3:0]  bit_cnt_q;
  logic [7:0]  shift_q;
  logic        rw_q, first_q, drive_low_q;
  logic        sda_in;
  logic        scl_rise, scl_fall, start_cond, stop_cond, byte_done;

  // Anything other than a clean 0 (z, x, 1) counts as released.
  assign sda_in = (sda === 1'b0) ? 1'b0 : 1'b1;
  assign sda    = drive_low_q ? 1'b0 : 1'bz;

  assign scl_rise   =  scl_s2_q & ~scl_prev_q;
  assign scl_fall   = ~scl_s2_q &  scl_prev_q;
  assign start_cond =  scl_s2_q &  sda_prev_q & ~sda_s2_q;
  assign stop_cond  =  scl_s2_q & ~sda_prev_q &  sda_s2_q;
  // bit_cnt counts 7..0 on sampled bits and wraps to 4'hF once bit 0 is in.
  assign byte_done  = (bit_cnt_q == 4'hF);

  // Two-stage synchronizers plus a history stage for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_s1_q   <= 1'b1;
      scl_s2_q   <= 1'b1;
      scl_prev_q <= 1'b1;
      sda_s1_q   <= 1'b1;
      sda_s2_q   <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_s1_q   <= scl;
      scl_s2_q   <= scl_s1_q;
      scl_prev_q <= scl_s2_q;
      sda_s1_q   <= sda_in;
      sda_s2_q   <= sda_s1_q;
      sda_prev_q <= sda_s2_q;
    end
  end

  // Protocol FSM; START/STOP override bit handling in every state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      rw_q        <= 1'b0;
      first_q     <= 1'b0;
      drive_low_q <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      rx_first    <= 1'b0;
      tx_load     <= 1'b0;
      mst_nack    <= 1'b0;
      busy        <= 1'b0;
      start_det   <= 1'b0;
      stop_det    <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      rx_first  <= 1'b0;
      tx_load   <= 1'b0;
      mst_nack  <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
      if (start_cond) begin
        state_q     <= S_ADDR;
        bit_cnt_q   <= 4'd7;
        shift_q     <= '0;
        start_det   <= 1'b1;
        busy        <= 1'b0;
        drive_low_q <= 1'b0;
      end else if (stop_cond) begin
        state_q     <= S_IDLE;
        stop_det    <= 1'b1;
        busy        <= 1'b0;
        drive_low_q <= 1'b0;
      end else begin
        case (state_q)
          S_ADDR, S_WRITE: begin
            if (scl_rise) begin
              shift_q   <= {shift_q[6:0], sda_s2_q};
              bit_cnt_q <= bit_cnt_q - 4'd1;
            end else if (scl_fall && byte_done) begin
              if (state_q == S_ADDR) begin
                if (shift_q[7:1] == SLAVE_ADDR) begin
                  drive_low_q <= 1'b1;
                  busy        <= 1'b1;
                  rw_q        <= shift_q[0];
                  state_q     <= S_ADDR_ACK;
                end else begin
                  drive_low_q <= 1'b0;
                  state_q     <= S_IGNORE;
                end
              end else begin
                drive_low_q <= 1'b1;
                rx_data     <= shift_q;
                rx_valid    <= 1'b1;
                rx_first    <= first_q;
                first_q     <= 1'b0;
                state_q     <= S_WR_ACK;
              end
            end
          end
          S_ADDR_ACK: begin
            if (scl_fall) begin
              bit_cnt_q <= 4'd7;
              if (rw_q) begin
                shift_q     <= tx_data;
                tx_load     <= 1'b1;
                drive_low_q <= ~tx_data[7];
                state_q     <= S_READ;
              end else begin
                drive_low_q <= 1'b0;
                first_q     <= 1'b1;
                state_q     <= S_WRITE;
              end
            end
          end
          S_WR_ACK: begin
            if (scl_fall) begin
              drive_low_q <= 1'b0;
              bit_cnt_q   <= 4'd7;
              state_q     <= S_WRITE;
            end
          end
          S_READ: begin
            if (scl_rise) begin
              bit_cnt_q <= bit_cnt_q - 4'd1;
            end else if (scl_fall) begin
              if (byte_done) begin
                drive_low_q <= 1'b0;
                state_q     <= S_RD_ACK;
              end else begin
                shift_q     <= {shift_q[6:0], 1'b0};
                drive_low_q <= ~shift_q[6];
              end
            end
          end
          S_RD_ACK: begin
            // A NACK leaves on the rise, so any fall seen here follows an ACK.
            if (scl_rise && sda_s2_q) begin
              mst_nack <= 1'b1;
              state_q  <= S_IGNORE;
            end else if (scl_fall) begin
              shift_q     <= tx_data;
              tx_load     <= 1'b1;
              drive_low_q <= ~tx_data[7];
              bit_cnt_q   <= 4'd7;
              state_q     <= S_READ;
            end
          end
          default: drive_low_q <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: bus-master model with SCL = clk/20.
module tb_i2c_slave;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       m_scl = 1'b1;
  logic       m_sda_low = 1'b0;
  logic [7:0] tx_data = 8'h00;
  wire        sda;
  logic       sda_v;
  logic [7:0] rx_data;
  logic       rx_valid, rx_first, tx_load, mst_nack, busy, start_det, stop_det;

  int n_cmp = 0;
  int n_bad = 0;
  int n_start = 0, n_stop = 0, n_txl = 0, n_nack = 0, n_viol = 0;
  logic [7:0] rx_b[$];
  logic       rx_f[$];

  pullup (sda);
  assign sda   = m_sda_low ? 1'b0 : 1'bz;
  assign sda_v = (sda === 1'b0) ? 1'b0 : 1'b1;

  i2c_slave #(.SLAVE_ADDR(7'h42)) dut (
    .clk(clk), .rst(rst), .scl(m_scl), .sda(sda),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_first(rx_first),
    .tx_data(tx_data), .tx_load(tx_load), .mst_nack(mst_nack),
    .busy(busy), .start_det(start_det), .stop_det(stop_det)
  );

  always #5 clk = ~clk;

  // Event monitor, sampled mid-cycle; also flags SDA moving while SCL is high
  // without the master having changed its own drive.
  logic prev_scl = 1'b1, prev_sda = 1'b1, prev_mlow = 1'b0, prev_rst = 1'b1;
  always begin
    @(negedge clk);
    #2;
    if (rx_valid) begin
      rx_b.push_back(rx_data);
      rx_f.push_back(rx_first);
    end
    n_start += int'(start_det);
    n_stop  += int'(stop_det);
    n_txl   += int'(tx_load);
    n_nack  += int'(mst_nack);
    if (!rst && !prev_rst && m_scl && prev_scl && (m_sda_low == prev_mlow) && (sda_v != prev_sda))
      n_viol++;
    prev_scl  = m_scl;
    prev_sda  = sda_v;
    prev_mlow = m_sda_low;
    prev_rst  = rst;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SCL period from SCL low: data set mid-low, sampled over the whole high phase.
  task automatic send_bit(input logic b, output logic r, output logic stable);
    wait_clk(5);
    m_sda_low = ~b;
    wait_clk(5);
    m_scl = 1'b1;
    stable = 1'b1;
    r = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wait_clk(1);
      if (i == 0) r = sda_v;
      else if (sda_v != r) stable = 1'b0;
    end
    m_scl = 1'b0;
  endtask

  task automatic bus_start();
    wait_clk(5);
    m_sda_low = 1'b0;
    wait_clk(5);
    m_scl = 1'b1;
    wait_clk(5);
    m_sda_low = 1'b1;
    wait_clk(5);
    m_scl = 1'b0;
  endtask

  task automatic bus_stop();
    wait_clk(5);
    m_sda_low = 1'b1;
    wait_clk(5);
    m_scl = 1'b1;
    wait_clk(5);
    m_sda_low = 1'b0;
    wait_clk(10);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack, output logic stable);
    logic r, s;
    for (int i = 7; i >= 0; i--) send_bit(d[i], r, s);
    send_bit(1'b1, ack, stable);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic r, s;
    for (int i = 7; i >= 0; i--) begin
      send_bit(1'b1, r, s);
      d[i] = r;
    end
    send_bit(nack, r, s);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wait_clk(5);
    n_cmp++;
    if ({rx_valid, rx_first, tx_load, mst_nack, busy, start_det, stop_det} !== 7'b0) begin
      n_bad++;
      $display("FAIL reset_flags: got %b want 0000000",
               {rx_valid, rx_first, tx_load, mst_nack, busy, start_det, stop_det});
    end
    n_cmp++;
    if (rx_data !== 8'h00) begin n_bad++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
    n_cmp++;
    if (sda_v !== 1'b1) begin n_bad++; $display("FAIL reset_sda: got %b want 1", sda_v); end
    rst = 1'b0;
    wait_clk(5);
  endtask

  task automatic test_write();
    int b_rx, b_st, b_sp;
    logic a, s;
    b_rx = rx_b.size(); b_st = n_start; b_sp = n_stop;
    bus_start();
    write_byte(8'h84, a, s);
    n_cmp++;
    if (a !== 1'b0) begin n_bad++; $display("FAIL wr_addr_ack: got %b want 0", a); end
    n_cmp++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL wr_busy: got %b want 1", busy); end
    write_byte(8'hA5, a, s);
    n_cmp++;
    if (a !== 1'b0) begin n_bad++; $display("FAIL wr_data1_ack: got %b want 0", a); end
    write_byte(8'h3C, a, s);
    n_cmp++;
    if (a !== 1'b0) begin n_bad++; $display("FAIL wr_data2_ack: got %b want 0", a); end
    bus_stop();
    n_cmp++;
    if (rx_b.size() - b_rx !== 2) begin
      n_bad++; $display("FAIL wr_rx_count: got %0d want 2", rx_b.size() - b_rx);
    end else begin
      n_cmp++;
      if ({rx_b[b_rx], rx_f[b_rx]} !== {8'hA5, 1'b1}) begin
        n_bad++; $display("FAIL wr_byte1: got %h/%b want a5/1", rx_b[b_rx], rx_f[b_rx]);
      end
      n_cmp++;
      if ({rx_b[b_rx+1], rx_f[b_rx+1]} !== {8'h3C, 1'b0}) begin
        n_bad++; $display("FAIL wr_byte2: got %h/%b want 3c/0", rx_b[b_rx+1], rx_f[b_rx+1]);
      end
    end
    n_cmp++;
    if ((n_start - b_st) !== 1 || (n_stop - b_sp) !== 1) begin
      n_bad++; $display("FAIL wr_start_stop: got %0d/%0d want 1/1", n_start - b_st, n_stop - b_sp);
    end
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL wr_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_read();
    int b_tl, b_nk;
    logic a, s;
    logic [7:0] d1, d2;
    b_tl = n_txl; b_nk = n_nack;
    tx_data = 8'h5A;
    bus_start();
    write_byte(8'h85, a, s);
    n_cmp++;
    if (a !== 1'b0) begin n_bad++; $display("FAIL rd_addr_ack: got %b want 0", a); end
    wait_clk(4);
    tx_data = 8'hC3;
    read_byte(1'b0, d1);
    read_byte(1'b1, d2);
    bus_stop();
    n_cmp++;
    if (d1 !== 8'h5A) begin n_bad++; $display("FAIL rd_byte1: got %h want 5a", d1); end
    n_cmp++;
    if (d2 !== 8'hC3) begin n_bad++; $display("FAIL rd_byte2: got %h want c3", d2); end
    n_cmp++;
    if ((n_txl - b_tl) !== 2) begin n_bad++; $display("FAIL rd_tx_load: got %0d want 2", n_txl - b_tl); end
    n_cmp++;
    if ((n_nack - b_nk) !== 1) begin n_bad++; $display("FAIL rd_mst_nack: got %0d want 1", n_nack - b_nk); end
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL rd_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_mismatch();
    int b_rx;
    logic a1, a2, s, bz;
    b_rx = rx_b.size();
    bus_start();
    write_byte(8'h90, a1, s);
    bz = busy;
    write_byte(8'h11, a2, s);
    bus_stop();
    n_cmp++;
    if ({a1, a2} !== 2'b11) begin n_bad++; $display("FAIL mm_acks: got %b%b want 11", a1, a2); end
    n_cmp++;
    if (bz !== 1'b0) begin n_bad++; $display("FAIL mm_busy: got %b want 0", bz); end
    n_cmp++;
    if (rx_b.size() != b_rx) begin n_bad++; $display("FAIL mm_rx: got %0d want 0", rx_b.size() - b_rx); end
  endtask

  task automatic test_rep_start();
    int b_rx, b_st, b_sp;
    logic a, s;
    logic [7:0] d;
    b_rx = rx_b.size(); b_st = n_start; b_sp = n_stop;
    tx_data = 8'h99;
    bus_start();
    write_byte(8'h84, a, s);
    write_byte(8'h77, a, s);
    bus_start();
    write_byte(8'h85, a, s);
    n_cmp++;
    if (a !== 1'b0) begin n_bad++; $display("FAIL rs_addr_ack: got %b want 0", a); end
    read_byte(1'b1, d);
    bus_stop();
    n_cmp++;
    if (rx_b.size() - b_rx !== 1) begin
      n_bad++; $display("FAIL rs_rx_count: got %0d want 1", rx_b.size() - b_rx);
    end else begin
      n_cmp++;
      if ({rx_b[b_rx], rx_f[b_rx]} !== {8'h77, 1'b1}) begin
        n_bad++; $display("FAIL rs_byte: got %h/%b want 77/1", rx_b[b_rx], rx_f[b_rx]);
      end
    end
    n_cmp++;
    if (d !== 8'h99) begin n_bad++; $display("FAIL rs_read: got %h want 99", d); end
    n_cmp++;
    if ((n_start - b_st) !== 2 || (n_stop - b_sp) !== 1) begin
      n_bad++; $display("FAIL rs_start_stop: got %0d/%0d want 2/1", n_start - b_st, n_stop - b_sp);
    end
  endtask

  task automatic test_timing();
    int b_v;
    logic a, s;
    logic [7:0] d;
    b_v = n_viol;
    tx_data = 8'h0F;
    bus_start();
    write_byte(8'h84, a, s);
    n_cmp++;
    if ({a, s} !== 2'b01) begin n_bad++; $display("FAIL tm_addr_ack_held: got ack=%b stable=%b want 0/1", a, s); end
    write_byte(8'h81, a, s);
    n_cmp++;
    if ({a, s} !== 2'b01) begin n_bad++; $display("FAIL tm_data_ack_held: got ack=%b stable=%b want 0/1", a, s); end
    bus_start();
    write_byte(8'h85, a, s);
    read_byte(1'b1, d);
    bus_stop();
    n_cmp++;
    if (d !== 8'h0F) begin n_bad++; $display("FAIL tm_read: got %h want 0f", d); end
    n_cmp++;
    if (n_viol != b_v) begin n_bad++; $display("FAIL tm_sda_while_scl_high: got %0d want 0", n_viol - b_v); end
  endtask

  task automatic test_abort();
    int b_rx, b_sp;
    logic r, s;
    logic [7:0] addr;
    b_rx = rx_b.size();
    addr = 8'h84;
    bus_start();
    for (int i = 7; i >= 0; i--) send_bit(addr[i], r, s);
    wait_clk(5);
    m_sda_low = 1'b0;
    wait_clk(5);
    m_scl = 1'b1;
    wait_clk(3);
    n_cmp++;
    if (sda_v !== 1'b0) begin n_bad++; $display("FAIL ab_ack_driven: got %b want 0", sda_v); end
    rst = 1'b1;
    wait_clk(1);
    n_cmp++;
    if (sda_v !== 1'b1) begin n_bad++; $display("FAIL ab_rst_release: got %b want 1", sda_v); end
    rst = 1'b0;
    wait_clk(6);
    m_scl = 1'b0;
    bus_stop();
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL ab_rst_busy: got %b want 0", busy); end
    // STOP in the middle of a write data byte.
    b_sp = n_stop;
    bus_start();
    for (int i = 7; i >= 0; i--) send_bit(addr[i], r, s);
    send_bit(1'b1, r, s);
    send_bit(1'b1, r, s);
    send_bit(1'b0, r, s);
    send_bit(1'b1, r, s);
    bus_stop();
    n_cmp++;
    if ((n_stop - b_sp) !== 1 || busy !== 1'b0 || sda_v !== 1'b1) begin
      n_bad++; $display("FAIL ab_stop_midbyte: got stops=%0d busy=%b sda=%b want 1/0/1",
                        n_stop - b_sp, busy, sda_v);
    end
    n_cmp++;
    if (rx_b.size() != b_rx) begin n_bad++; $display("FAIL ab_rx: got %0d want 0", rx_b.size() - b_rx); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_mismatch();
    test_rep_start();
    test_timing();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
